// File: rtl/max_result_tx.sv
// max_result_tx: snapshots the final alignment max (score,row,col) on start
// and streams it to the host over a valid/ready beat stream, LSB beat first.
// Ports: clk, rst_n (sync, active-low), start, max_score/max_row/max_col in;
//        data_ready in; data_out, data_valid, data_last, busy, done out.
// Option: define MAX_RESULT_TX_CHECKSUM_EN to append an XOR checksum beat.
module max_result_tx #(
  parameter int SCORE_WIDTH    = 10,
  parameter int ROW_BITS_WIDTH = 5,
  parameter int COL_BITS_WIDTH = 5,
  parameter int OUT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SCORE_WIDTH-1:0]    max_score,
  input  logic [ROW_BITS_WIDTH-1:0] max_row,
  input  logic [COL_BITS_WIDTH-1:0] max_col,
  input  logic                      data_ready,
  output logic [OUT_WIDTH-1:0]      data_out,
  output logic                      data_valid,
  output logic                      data_last,
  output logic                      busy,
  output logic                      done
);

  localparam int TOTAL_W =
    SCORE_WIDTH + ROW_BITS_WIDTH + COL_BITS_WIDTH;
  localparam int NUM_BEATS =
    (TOTAL_W + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int SNAP_W = NUM_BEATS * OUT_WIDTH;
  localparam int CNT_W  = $clog2(NUM_BEATS + 1);

`ifdef MAX_RESULT_TX_CHECKSUM_EN
  localparam int FRAME_BEATS = NUM_BEATS + 1;
`else
  localparam int FRAME_BEATS = NUM_BEATS;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(FRAME_BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SNAP_W-1:0]    snap_q, snap_d;
  logic [OUT_WIDTH-1:0] data_beat;
  logic [OUT_WIDTH-1:0] cur_beat;
  logic                 in_send;
  logic                 xfer;
  logic                 at_last;

  assign in_send = (state_q == S_SEND);
  assign at_last = (cnt_q == LAST_CNT);
  assign xfer    = in_send && data_ready;

  // Data beat selected by the counter using constant slices.
  always_comb begin
    data_beat = '0;
    for (int i = 0; i < NUM_BEATS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        data_beat = snap_q[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

`ifdef MAX_RESULT_TX_CHECKSUM_EN
  logic [OUT_WIDTH-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_BEATS; i++) begin
      csum = csum ^ snap_q[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // The beat after the last data beat carries the checksum.
  assign cur_beat =
    (cnt_q == CNT_W'(NUM_BEATS)) ? csum : data_beat;
`else
  assign cur_beat = data_beat;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d = '0;
          snap_d[TOTAL_W-1:0] = {max_col, max_row, max_score};
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  // Outputs depend on registered state only, never on data_ready.
  assign data_valid = in_send;
  assign data_last  = in_send && at_last;
  assign data_out   = in_send ? cur_beat : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_max_result_tx.sv
// tb_max_result_tx: directed scoreboard bench for max_result_tx.
// Expected beats are queued when a frame is started, checked on transfer.
module tb_max_result_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       data_ready = 1'b1;
  logic [9:0] max_score = '0;
  logic [4:0] max_row = '0;
  logic [4:0] max_col = '0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_last;
  logic       busy;
  logic       done;

`ifdef MAX_RESULT_TX_CHECKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  max_result_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .max_score  (max_score),
    .max_row    (max_row),
    .max_col    (max_col),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_last  (data_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_lit(input logic [7:0] b0,
                          input logic [7:0] b1,
                          input logic [7:0] b2,
                          input logic [7:0] ck);
`ifdef MAX_RESULT_TX_CHECKSUM_EN
    exp_q.push_back('{b0, 1'b0});
    exp_q.push_back('{b1, 1'b0});
    exp_q.push_back('{b2, 1'b0});
    exp_q.push_back('{ck, 1'b1});
`else
    exp_q.push_back('{b0, 1'b0});
    exp_q.push_back('{b1, 1'b0});
    exp_q.push_back('{b2, 1'b1});
    if (ck == 8'h00) begin end
`endif
  endtask

  task automatic push_model(input logic [9:0] s,
                            input logic [4:0] r,
                            input logic [4:0] c);
    logic [23:0] v;
    v = {4'b0, c, r, s};
    push_lit(v[7:0], v[15:8], v[23:16],
             v[7:0] ^ v[15:8] ^ v[23:16]);
  endtask

  // Check any beat transferred at the coming edge, then advance.
  task automatic tick();
    beat_t e;
    if (rst_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", {24'b0, data_out}, {24'b0, e.d});
        chk("beat_last", {31'b0, data_last}, {31'b0, e.l});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [9:0] s,
                             input logic [4:0] r,
                             input logic [4:0] c);
    max_score = s;
    max_row   = r;
    max_col   = c;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("first_valid", {31'b0, data_valid}, 1);
    chk("first_busy", {31'b0, busy}, 1);
  endtask

  task automatic run_to_done(input int expect_n,
                             input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, expect_n);
    chk("done_busy", {31'b0, busy}, 1);
    chk("done_valid", {31'b0, data_valid}, 0);
    tick();
    chk("done_pulse_len", {31'b0, done}, 0);
    chk("idle_busy", {31'b0, busy}, 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_data", {24'b0, data_out}, 0);
    chk("rst_valid", {31'b0, data_valid}, 0);
    chk("rst_last", {31'b0, data_last}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    tick();

    // Basic frame, ready high
    push_lit(8'hA5, 8'h4E, 8'h06, 8'hED);
    start_frame(10'h2A5, 5'h13, 5'h0C);
    chk("basic_b0", {24'b0, data_out}, 32'hA5);
    run_to_done(FB, "lat_basic");

    // Back-to-back: start in the first IDLE cycle
    push_model(10'h0, 5'h0, 5'h0);
    start_frame(10'h0, 5'h0, 5'h0);
    run_to_done(FB, "lat_b2b");

    // Backpressure on beat 1
    push_lit(8'hA5, 8'h4E, 8'h06, 8'hED);
    start_frame(10'h2A5, 5'h13, 5'h0C);
    tick();
    data_ready = 1'b0;
    repeat (3) begin
      chk("bp_data", {24'b0, data_out}, 32'h4E);
      chk("bp_valid", {31'b0, data_valid}, 1);
      chk("bp_last", {31'b0, data_last}, 0);
      tick();
    end
    data_ready = 1'b1;
    run_to_done(FB - 1, "lat_bp");

    // Snapshot isolation and ignored start
    push_lit(8'hA5, 8'h4E, 8'h06, 8'hED);
    start_frame(10'h2A5, 5'h13, 5'h0C);
    tick();
    max_score = 10'h3FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(FB - 2, "lat_iso");
    repeat (4) begin
      tick();
      chk("iso_no_done", {31'b0, done}, 0);
      chk("iso_idle", {31'b0, busy}, 0);
    end

    // Reset mid-frame
    push_lit(8'hA5, 8'h4E, 8'h06, 8'hED);
    start_frame(10'h2A5, 5'h13, 5'h0C);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_data", {24'b0, data_out}, 0);
    chk("mrst_valid", {31'b0, data_valid}, 0);
    chk("mrst_last", {31'b0, data_last}, 0);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_done", {31'b0, done}, 0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) begin
      tick();
      chk("mrst_no_done", {31'b0, done}, 0);
    end

    // Max values after reset
    push_lit(8'hFF, 8'hFF, 8'h0F, 8'h0F);
    start_frame(10'h3FF, 5'h1F, 5'h1F);
    chk("max_b0", {24'b0, data_out}, 32'hFF);
    run_to_done(FB, "lat_max");

    // A few random frames with random backpressure
    for (int k = 0; k < 4; k++) begin
      logic [9:0] s;
      logic [4:0] r;
      logic [4:0] c;
      int n;
      s = 10'($urandom);
      r = 5'($urandom);
      c = 5'($urandom);
      push_model(s, r, c);
      start_frame(s, r, c);
      n = 0;
      while (!done && n < 60) begin
        data_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      data_ready = 1'b1;
      chk("rnd_done", {31'b0, done}, 1);
      tick();
      chk("rnd_drained", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max_result_tx.md
# max_result_tx

Reads the final alignment result (max score, row, col) out of the max-tracking registers when the controller signals end of alignment. Latches a snapshot, then transmits it to the host over a narrow valid/ready stream, LSB beat first. Sits between the max registers/controller and the accelerator's external result port.

## Interface
Parameters:
- SCORE_WIDTH, 10, width of the max score
- ROW_BITS_WIDTH, 5, width of the row index
- COL_BITS_WIDTH, 5, width of the col index
- OUT_WIDTH, 8, width of one output beat
- Derived: TOTAL_W = SCORE_WIDTH+ROW_BITS_WIDTH+COL_BITS_WIDTH; NUM_BEATS = ceil(TOTAL_W/OUT_WIDTH); defaults give 3 beats

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request from controller: alignment finished, send result
- max_score  in  SCORE_WIDTH  current max score
- max_row  in  ROW_BITS_WIDTH  row of max score
- max_col  in  COL_BITS_WIDTH  col of max score
- data_ready  in  1  host can accept a beat
- data_out  out  OUT_WIDTH  current beat
- data_valid  out  1  data_out holds a valid beat
- data_last  out  1  current beat is the final beat of the frame
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse after the final beat is accepted

## Operation
- States: IDLE, SEND, DONE.
- IDLE: data_valid=0. On start=1, latch snapshot = zero-pad to NUM_BEATS*OUT_WIDTH of {max_col, max_row, max_score} (score in LSBs, col in MSBs), clear beat counter, go SEND.
- SEND: data_out = snapshot bits [cnt*OUT_WIDTH +: OUT_WIDTH]; data_valid=1. A beat transfers on data_valid && data_ready; counter increments. data_last=1 when cnt == NUM_BEATS-1. Transfer of the last beat -> DONE.
- DONE: done=1 for exactly one cycle, data_valid=0, -> IDLE.
- data_out, data_last stable while data_valid=1 and data_ready=0; they change only after a transfer.
- start outside IDLE is ignored; snapshot is not re-latched. Changes on max_* after latching have no effect on the frame in flight.
- data_ready while data_valid=0 has no effect.
- Beat counter width clog2(NUM_BEATS+1); never exceeds NUM_BEATS-1 in SEND (no wrap).
- Outside SEND, data_out drives 0.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, counter 0, snapshot 0; data_out=0, data_valid=0, data_last=0, busy=0, done=0. Applies mid-frame: frame is abandoned, no done pulse.
- start sampled at edge N -> data_valid=1 with beat 0 from cycle N+1.
- With data_ready held high: one beat per cycle; last beat at cycle N+NUM_BEATS; done=1 in cycle N+NUM_BEATS+1; IDLE (start accepted again) from N+NUM_BEATS+2.
- busy high from N+1 through the done cycle inclusive.
- No combinational path from data_ready to data_valid or data_out.

## Configuration
- MAX_RESULT_TX_CHECKSUM_EN defined: frame carries one extra beat after the data beats, equal to the XOR of all NUM_BEATS data beats; data_last moves to the checksum beat; frame length NUM_BEATS+1, done and all later timing shift by one cycle.
- Not defined: frame is exactly NUM_BEATS data beats, data_last on beat NUM_BEATS-1, no checksum logic present.

## Test plan
- Basic frame, ready always high: score=0x2A5, row=0x13, col=0x0C, start pulse -> beats 0xA5, 0x4E, 0x06 on consecutive cycles, data_last only on 0x06, done one cycle later; with MAX_RESULT_TX_CHECKSUM_EN a fourth beat 0xED carries data_last.
- Backpressure: same values, data_ready low for 3 cycles during beat 1 -> data_out held at 0x4E with data_valid=1 and no counter advance; frame completes intact afterwards.
- Snapshot isolation: change max_score to 0x3FF and pulse start again during SEND -> frame still sends 0xA5, 0x4E, 0x06; second start ignored, exactly one done.
- Reset mid-frame: rst_n low after beat 0 is accepted -> next cycle all outputs 0, state IDLE, no done; fresh start after release sends a full frame from beat 0.
- Back-to-back frames: start asserted in first IDLE cycle after done with score=0, row=0, col=0 -> beats 0x00, 0x00, 0x00 (checksum 0x00 if enabled), busy low for exactly the one IDLE cycle between frames.
- Max values: score=0x3FF, row=0x1F, col=0x1F -> beats 0xFF, 0xFF, 0x0F (pad bits zero); checksum 0x0F if enabled.
